// File: rtl/decode_issue_queue.sv
// decode_issue_queue: circular instruction buffer between a 2-wide fetch and
// a 2-wide decode/rename stage.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   flush             : synchronous discard of all entries (branch redirect)
//   fetch_valid/inst/pc, fetch_ready : 2-lane enqueue side (lane0 older)
//   dec_valid/inst/pc, dec_ready     : 2-slot issue side (slot0 older)
//   count             : occupied entries
// Each entry holds a word, its PC and two predecode bits (is_br, is_mem)
// that restrict dual issue: no second slot behind a branch, and at most one
// memory op per group.
module decode_issue_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               fetch_valid,
    input  logic [63:0]              fetch_inst,
    input  logic [31:0]              fetch_pc,
    output logic                     fetch_ready,
    input  logic                     dec_ready,
    output logic [1:0]               dec_valid,
    output logic [63:0]              dec_inst,
    output logic [63:0]              dec_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Branch/jump class: opcodes 1..7, plus jr/jalr in the special opcode.
    function automatic logic pre_br(input logic [5:0] op, input logic [5:0] fn);
        pre_br = ((op >= 6'd1) && (op <= 6'd7)) ||
                 ((op == 6'd0) && ((fn == 6'b001000) || (fn == 6'b001001)));
    endfunction

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] br_q;
    logic [DEPTH-1:0] mem_q;

    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic [AW-1:0] head1;
    logic [AW-1:0] tail1;
    logic          slot0_ok;
    logic          slot1_ok;
    logic          wr0_en;
    logic          wr1_en;
    logic [31:0]   wr0_inst;
    logic [31:0]   wr0_pc;
    logic [31:0]   pc_lane1;
    logic [CW-1:0] pushed;
    logic [CW-1:0] popped;

    assign count    = count_q;
    assign head1    = head_q + AW'(1);
    assign tail1    = tail_q + AW'(1);
    assign pc_lane1 = fetch_pc + 32'd4;

    // Room is judged on the registered count only, never on a same-cycle pop.
    assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(2);

    // Issue side: head on slot0, head+1 on slot1 when pairing is legal.
    always_comb begin
        dec_valid = 2'b00;
        dec_inst  = 64'd0;
        dec_pc    = 64'd0;
        slot0_ok  = (count_q != CW'(0));
        slot1_ok  = (count_q >= CW'(2)) && !br_q[head_q] &&
                    !(mem_q[head_q] && mem_q[head1]);
        if (!flush) begin
            dec_valid = {slot1_ok, slot0_ok};
        end
        if (dec_valid[0]) begin
            dec_inst[31:0] = inst_q[head_q];
            dec_pc[31:0]   = pc_q[head_q];
        end
        if (dec_valid[1]) begin
            dec_inst[63:32] = inst_q[head1];
            dec_pc[63:32]   = pc_q[head1];
        end
    end

    // Enqueue steering: valid lanes are packed in order starting at tail.
    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_inst = fetch_inst[31:0];
        wr0_pc   = fetch_pc;
        if (fetch_ready && !flush) begin
            case (fetch_valid)
                2'b01: wr0_en = 1'b1;
                2'b10: begin
                    wr0_en   = 1'b1;
                    wr0_inst = fetch_inst[63:32];
                    wr0_pc   = pc_lane1;
                end
                2'b11: begin
                    wr0_en = 1'b1;
                    wr1_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Occupancy deltas for this cycle.
    always_comb begin
        pushed = CW'(wr0_en) + CW'(wr1_en);
        popped = CW'(0);
        if (dec_ready && !flush) begin
            popped = CW'(dec_valid[0]) + CW'(dec_valid[1]);
        end
    end

    // Entry storage; contents are don't-care outside [head, head+count).
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            inst_q[tail_q] <= wr0_inst;
            pc_q[tail_q]   <= wr0_pc;
            br_q[tail_q]   <= pre_br(wr0_inst[31:26], wr0_inst[5:0]);
            mem_q[tail_q]  <= wr0_inst[31];
        end
        if (wr1_en) begin
            inst_q[tail1] <= fetch_inst[63:32];
            pc_q[tail1]   <= pc_lane1;
            br_q[tail1]   <= pre_br(fetch_inst[63:58], fetch_inst[37:32]);
            mem_q[tail1]  <= fetch_inst[63];
        end
    end

    // Pointers and occupancy; flush overrides same-cycle push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(popped);
            tail_q  <= tail_q + AW'(pushed);
            count_q <= count_q + pushed - popped;
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: vector table for basic issue rules,
// then hand sequences for fill/backpressure, wrap, flush and async reset.
module tb_decode_issue_queue;

    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  fetch_valid;
    logic [63:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        dec_ready;
    logic [1:0]  dec_valid;
    logic [63:0] dec_inst;
    logic [63:0] dec_pc;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    decode_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [1:0]  fv;
        logic [63:0] fi;
        logic [31:0] fpc;
        logic        dr;
        logic [1:0]  e_dv;
        logic [63:0] e_inst;
        logic [63:0] e_pc;
        logic [3:0]  e_cnt;
        logic        e_fr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] fv, input logic [63:0] fi,
                         input logic [31:0] fpc, input logic dr);
        fetch_valid = fv;
        fetch_inst  = fi;
        fetch_pc    = fpc;
        dec_ready   = dr;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive(2'b00, 64'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Reference predecode and word generator for the streaming section.
    function automatic logic m_br(input logic [31:0] w);
        m_br = (w[31:26] inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}) ||
               (w[31:26] == 6'd0 && (w[5:0] == 6'h08 || w[5:0] == 6'h09));
    endfunction

    function automatic logic m_mem(input logic [31:0] w);
        m_mem = w[31];
    endfunction

    function automatic logic [31:0] mk(input int idx);
        logic [31:0] tag;
        tag = 32'(idx) << 6;
        case (idx % 8)
            0, 6, 7: mk = 32'h0000_0020 | tag;  // add
            1, 3:    mk = 32'h8C00_0000 | tag;  // lw
            2:       mk = 32'h1000_0000 | tag;  // beq
            4:       mk = 32'hAC00_0000 | tag;  // sw
            default: mk = 32'h0000_0008 | tag;  // jr
        endcase
    endfunction

    logic [63:0] mq[$];

    initial begin
        // flush, fv, fi, fpc, dr | dv, inst, pc, count, fetch_ready
        vecs[0]  = '{1'b0, 2'b11, 64'h8C880004_012A4020, 32'h100, 1'b1, 2'b00, 64'h0, 64'h0, 4'd0, 1'b1};
        vecs[1]  = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 2'b11, 64'h8C880004_012A4020, 64'h00000104_00000100, 4'd2, 1'b1};
        vecs[2]  = '{1'b0, 2'b01, 64'h00000000_10220003, 32'h200, 1'b0, 2'b00, 64'h0, 64'h0, 4'd0, 1'b1};
        vecs[3]  = '{1'b0, 2'b01, 64'h00000000_00000020, 32'h204, 1'b0, 2'b01, 64'h10220003, 64'h200, 4'd1, 1'b1};
        vecs[4]  = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 2'b01, 64'h10220003, 64'h200, 4'd2, 1'b1};
        vecs[5]  = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 2'b01, 64'h10220003, 64'h200, 4'd2, 1'b1};
        vecs[6]  = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 2'b01, 64'h00000020, 64'h204, 4'd1, 1'b1};
        vecs[7]  = '{1'b0, 2'b11, 64'hAC880008_8C880004, 32'h300, 1'b0, 2'b00, 64'h0, 64'h0, 4'd0, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 2'b01, 64'h8C880004, 64'h300, 4'd2, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 2'b01, 64'hAC880008, 64'h304, 4'd1, 1'b1};
        vecs[10] = '{1'b0, 2'b10, 64'h012A4020_DEADBEEF, 32'h400, 1'b0, 2'b00, 64'h0, 64'h0, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 2'b01, 64'h012A4020, 64'h404, 4'd1, 1'b1};
        vecs[12] = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 2'b01, 64'h012A4020, 64'h404, 4'd1, 1'b1};
        vecs[13] = '{1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 2'b00, 64'h0, 64'h0, 4'd0, 1'b1};

        // Reset state, checked while reset is held and after release.
        rst   = 1'b1;
        flush = 1'b0;
        drive(2'b00, 64'd0, 32'd0, 1'b0);
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        do_reset();

        // Table-driven basic issue behaviour.
        for (int i = 0; i < 14; i++) begin
            tick();
            flush = vecs[i].flush;
            drive(vecs[i].fv, vecs[i].fi, vecs[i].fpc, vecs[i].dr);
            #1;
            chk($sformatf("v%0d_dec_valid", i), 64'(dec_valid), 64'(vecs[i].e_dv));
            chk($sformatf("v%0d_dec_inst", i), dec_inst, vecs[i].e_inst);
            chk($sformatf("v%0d_dec_pc", i), dec_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_fetch_ready", i), 64'(fetch_ready), 64'(vecs[i].e_fr));
        end

        // Fill to DEPTH with jumps (always single issue), check backpressure.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(2'b11, {32'h0800_0000 | 32'(2*i+1), 32'h0800_0000 | 32'(2*i)},
                  32'h2000 + 32'(8*i), 1'b0);
            #1;
            chk($sformatf("fill%0d_count", i), 64'(count), 64'(2*i));
            chk($sformatf("fill%0d_fetch_ready", i), 64'(fetch_ready), 64'd1);
        end
        tick();
        drive(2'b00, 64'd0, 32'd0, 1'b1);
        #1;
        chk("full_count", 64'(count), 64'd8);
        chk("full_fetch_ready", 64'(fetch_ready), 64'd0);
        chk("full_dec_valid", 64'(dec_valid), 64'd1);
        tick();
        drive(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 32'h9000, 1'b0);
        #1;
        chk("cnt7_count", 64'(count), 64'd7);
        chk("cnt7_fetch_ready", 64'(fetch_ready), 64'd0);
        tick();
        drive(2'b00, 64'd0, 32'd0, 1'b1);
        #1;
        chk("cnt7_no_push", 64'(count), 64'd7);
        for (int j = 1; j < 8; j++) begin
            chk($sformatf("drain%0d_inst", j), dec_inst, 64'(32'h0800_0000 | 32'(j)));
            chk($sformatf("drain%0d_pc", j), dec_pc, 64'(32'h2000 + 32'(4*j)));
            tick();
        end
        chk("drain_count", 64'(count), 64'd0);

        // Streaming mix with backpressure; exercises wrap and pairing rules.
        do_reset();
        mq.delete();
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  fv;
            logic        dr;
            logic        e0;
            logic        e1;
            int          freeb;
            logic [31:0] pc;
            tick();
            dr = (k % 3) != 2;
            case (k % 5)
                2: fv = 2'b01;
                3: fv = 2'b10;
                4: fv = 2'b00;
                default: fv = 2'b11;
            endcase
            pc = 32'h1000 + 32'(8 * k);
            drive(fv, {mk(2*k+1), mk(2*k)}, pc, dr);
            #1;
            e0 = mq.size() >= 1;
            e1 = (mq.size() >= 2) && !m_br(mq[0][31:0]) &&
                 !(m_mem(mq[0][31:0]) && m_mem(mq[1][31:0]));
            chk($sformatf("s%0d_dec_valid", k), 64'(dec_valid), 64'({e1, e0}));
            chk($sformatf("s%0d_slot0", k), {dec_pc[31:0], dec_inst[31:0]}, e0 ? mq[0] : 64'd0);
            chk($sformatf("s%0d_slot1", k), {dec_pc[63:32], dec_inst[63:32]}, e1 ? mq[1] : 64'd0);
            chk($sformatf("s%0d_count", k), 64'(count), 64'(mq.size()));
            freeb = DEPTH - mq.size();
            chk($sformatf("s%0d_fetch_ready", k), 64'(fetch_ready), 64'(freeb >= 2));
            if (dr && e0) void'(mq.pop_front());
            if (dr && e1) void'(mq.pop_front());
            if (freeb >= 2) begin
                if (fv[0]) mq.push_back({pc, mk(2*k)});
                if (fv[1]) mq.push_back({pc + 32'd4, mk(2*k+1)});
            end
        end

        // Flush with count=5 and simultaneous push/pop requests.
        do_reset();
        tick(); drive(2'b11, {32'h0000_0060, 32'h0000_0020}, 32'h500, 1'b0);
        tick(); drive(2'b11, {32'h0000_00A0, 32'h0000_0060}, 32'h508, 1'b0);
        tick(); drive(2'b01, 64'h0000_0020, 32'h510, 1'b0);
        tick();
        flush = 1'b1;
        drive(2'b11, 64'h0000_0020_0000_0020, 32'h600, 1'b1);
        #1;
        chk("flush_pre_count", 64'(count), 64'd5);
        chk("flush_dec_valid", 64'(dec_valid), 64'd0);
        chk("flush_dec_inst", dec_inst, 64'd0);
        chk("flush_dec_pc", dec_pc, 64'd0);
        tick();
        flush = 1'b0;
        drive(2'b00, 64'd0, 32'd0, 1'b1);
        #1;
        chk("flush_post_count", 64'(count), 64'd0);
        chk("flush_post_dec_valid", 64'(dec_valid), 64'd0);
        tick();
        chk("flush_post2_count", 64'(count), 64'd0);

        // Asynchronous reset between edges.
        tick(); drive(2'b11, 64'h0000_0020_0000_0020, 32'h700, 1'b0);
        tick(); drive(2'b11, 64'h0000_0020_0000_0020, 32'h708, 1'b0);
        tick();
        drive(2'b00, 64'd0, 32'd0, 1'b0);
        chk("pre_async_count", 64'(count), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_dec_valid", 64'(dec_valid), 64'd0);
        chk("async_fetch_ready", 64'(fetch_ready), 64'd1);
        #2;
        rst = 1'b0;
        tick();
        chk("async_after_count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of instruction entries (power of 2, >=4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, synchronous discard of all queued entries (branch redirect).
REQ-005 SHALL have port fetch_valid, input, 2, per-lane valid; lane0 is older.
REQ-006 SHALL have port fetch_inst, input, 64, {lane1 word, lane0 word}.
REQ-007 SHALL have port fetch_pc, input, 32, PC of lane0; lane1 PC is fetch_pc+4.
REQ-008 SHALL have port fetch_ready, output, 1, high when free entries >= 2.
REQ-009 SHALL have port dec_ready, input, 1, decode/rename accepts the offered group this cycle.
REQ-010 SHALL have port dec_valid, output, 2, slot valids for the two downstream decoders; slot0 is older.
REQ-011 SHALL have port dec_inst, output, 64, {slot1 word, slot0 word}.
REQ-012 SHALL have port dec_pc, output, 64, {slot1 PC, slot0 PC}.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, occupied entries.

Function
REQ-014 SHALL store per entry a 32-bit word, a 32-bit PC and two predecode bits, is_br and is_mem, computed at enqueue.
REQ-015 SHALL set is_br for opcode 000010, 000011, 000100, 000101, 000110, 000111 or 000001, and for opcode 000000 with funct 001000 or 001001.
REQ-016 SHALL set is_mem when opcode[5]=1 (loads and stores).
REQ-017 SHALL enqueue only when fetch_ready=1. Valid lanes are written in order at tail, then tail+1; fetch_valid=2'b10 writes lane1 alone at tail with PC fetch_pc+4.
REQ-018 SHALL compute fetch_ready from the registered count only (DEPTH-count >= 2), ignoring any same-cycle dequeue.
REQ-019 SHALL present the head entry combinationally on slot0; dec_valid[0]=1 when count>=1.
REQ-020 SHALL drive dec_valid[1]=1 only when count>=2, head is_br=0, and not both head and head+1 have is_mem=1.
REQ-021 SHALL drive dec_inst/dec_pc slots to zero whenever the matching dec_valid bit is 0.
REQ-022 SHALL pop popcount(dec_valid) entries when dec_ready=1; dec_valid and data SHALL hold stable while dec_ready=0 and flush=0.
REQ-023 SHALL allow enqueue and dequeue in the same cycle: count_next = count + pushed - popped.
REQ-024 SHALL make an enqueued word visible on dec outputs the cycle after its write edge (1-cycle latency, no bypass).
REQ-025 SHALL wrap head and tail modulo DEPTH; full and empty are distinguished by count only.
REQ-026 SHALL, when flush=1, force dec_valid=2'b00 that cycle. At the edge it SHALL reset head, tail and count to 0, with priority over same-cycle enqueue and dequeue.
REQ-027 SHALL never overflow or underflow; count SHALL remain within 0..DEPTH.

Reset
REQ-028 SHALL on rst=1, immediately and independent of clk, set head=0, tail=0, count=0, dec_valid=0, fetch_ready=1.
REQ-029 SHALL discard entries in flight at reset; entry storage need not be cleared.

Verification
REQ-030 SHALL pass: rst, then enqueue 0x012A4020 @0x100 and 0x8C880004 @0x104, dec_ready=1 -> next cycle dec_valid=11 with both words and PCs, then count=0.
REQ-031 SHALL pass: queue head 0x10220003 (beq) followed by 0x00000020 -> dec_valid=01 only; after pop, the add is offered alone as slot0.
REQ-032 SHALL pass: head lw 0x8C880004 followed by sw 0xAC880008 -> dec_valid=01; the sw issues the next cycle.
REQ-033 SHALL pass: fill 8 entries with dec_ready=0 -> count=8, fetch_ready=0; at count=7 fetch_ready=0; wrap after 3 refills keeps order.
REQ-034 SHALL pass: flush=1 with count=5, fetch_valid=11 and dec_ready=1 -> dec_valid=00 that cycle; count=0 next cycle; no entry is issued.
REQ-035 SHALL pass: rst asserted mid-burst between edges -> count=0 and dec_valid=00 before the next clk edge.
